alt_vipvfr131_vfr_bank_scheduler: RTL

Double-buffer bank scheduler that sequences the frame-reader controller. It tracks which of the two frame banks the producer (frame writer) is filling and which bank is on display. It drives the controller's `go_bit`/`next_bank` once per frame, swapping banks when a new frame is ready and repeating the last bank otherwise. It also keeps frame, repeat and drop counters for the Avalon slave status registers.

---
 rtl/alt_vipvfr131_vfr_bank_scheduler_if.sv | 30 +++
 rtl/alt_vipvfr131_vfr_bank_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alt_vipvfr131_vfr_bank_scheduler_if.sv
// Handshake bundle between the bank scheduler, the frame writer, the frame-reader
// controller and the status registers.
interface alt_vipvfr131_vfr_bank_scheduler_if #(
  parameter int unsigned COUNT_WIDTH = 16
) ();
  logic                   enable;
  logic                   writer_done;
  logic                   writer_bank;
  logic                   go_bit;
  logic                   next_bank;
  logic                   running;
  logic                   frame_complete;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] frame_count;
  logic [COUNT_WIDTH-1:0] repeat_count;
  logic [COUNT_WIDTH-1:0] drop_count;
  logic                   timeout;

  modport slave (
    input  enable, writer_done, running, frame_complete,
    output writer_bank, go_bit, next_bank, busy, frame_count, repeat_count, drop_count,
           timeout
  );

  modport master (
    output enable, writer_done, running, frame_complete,
    input  writer_bank, go_bit, next_bank, busy, frame_count, repeat_count, drop_count,
           timeout
  );
endinterface

// File: rtl/alt_vipvfr131_vfr_bank_scheduler.sv
// Double-buffer bank scheduler for the frame reader: swaps banks when a frame is ready,
// repeats otherwise. Optional watchdog enabled by ALT_VIPVFR_SCHED_TIMEOUT_EN.
module alt_vipvfr131_vfr_bank_scheduler #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 24
) (
  input logic                                  clock,
  input logic                                  reset_n,
  alt_vipvfr131_vfr_bank_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StActive} state_e;

  state_e                 state_q, state_d;
  logic                   go_bit_q, go_bit_d;
  logic                   next_bank_q, next_bank_d;
  logic                   writer_bank_q, writer_bank_d;
  logic                   pending_q, pending_d;
  logic                   have_valid_q, have_valid_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0] repeat_count_q, repeat_count_d;
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                   swap;
  logic                   wd_expire;

`ifdef ALT_VIPVFR_SCHED_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  assign wd_expire = (state_q != StIdle) && (wd_q == TIMEOUT_CYCLES - 32'd1);
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    go_bit_d       = go_bit_q;
    next_bank_d    = next_bank_q;
    writer_bank_d  = writer_bank_q;
    have_valid_d   = have_valid_q;
    frame_count_d  = frame_count_q;
    repeat_count_d = repeat_count_q;
    drop_count_d   = drop_count_q;
    swap           = 1'b0;

    // A new writer_done lands before any swap decided this cycle.
    pending_d = pending_q | bus.writer_done;
    if (bus.writer_done && pending_q) drop_count_d = drop_count_q + COUNT_WIDTH'(1);

    if (wd_expire) begin
      go_bit_d = 1'b0;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          go_bit_d = 1'b0;
          if (bus.enable && (pending_d || have_valid_q)) begin
            swap     = pending_d;
            go_bit_d = 1'b1;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (bus.running) begin
            go_bit_d = 1'b0;
            state_d  = StActive;
          end
        end
        StActive: begin
          if (bus.frame_complete) begin
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
            if (bus.enable) begin
              if (pending_d) swap = 1'b1;
              else repeat_count_d = repeat_count_q + COUNT_WIDTH'(1);
              go_bit_d = 1'b1;
              state_d  = StIssue;
            end else begin
              // Swap is deferred; pending survives until the next start from idle.
              state_d = StIdle;
            end
          end
        end
        default: begin
          go_bit_d = 1'b0;
          state_d  = StIdle;
        end
      endcase
    end

    if (swap) begin
      next_bank_d   = writer_bank_q;
      writer_bank_d = ~writer_bank_q;
      pending_d     = 1'b0;
      have_valid_d  = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

`ifdef ALT_VIPVFR_SCHED_TIMEOUT_EN
  always_comb begin
    timeout_d = timeout_q | wd_expire;
    wd_d      = ((state_d == state_q) && (state_q != StIdle)) ? wd_q + 32'd1 : 32'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      go_bit_q       <= 1'b0;
      next_bank_q    <= 1'b0;
      writer_bank_q  <= 1'b0;
      pending_q      <= 1'b0;
      have_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_count_q  <= '0;
      repeat_count_q <= '0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      go_bit_q       <= go_bit_d;
      next_bank_q    <= next_bank_d;
      writer_bank_q  <= writer_bank_d;
      pending_q      <= pending_d;
      have_valid_q   <= have_valid_d;
      busy_q         <= busy_d;
      frame_count_q  <= frame_count_d;
      repeat_count_q <= repeat_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign bus.go_bit       = go_bit_q;
  assign bus.next_bank    = next_bank_q;
  assign bus.writer_bank  = writer_bank_q;
  assign bus.busy         = busy_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.repeat_count = repeat_count_q;
  assign bus.drop_count   = drop_count_q;

endmodule
